// File: rtl/g15_accessory_pkg.sv
// Shared types and constants for the G-15 accessory port replacement.
package g15_accessory_pkg;

    localparam int G15_WORD_W = 29;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFTING
    } in_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and a memory-read head.
// Push is ignored when full and pop is ignored when empty; both may happen in one cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/accessory_port.sv
// Word-buffered host interface standing in for the photo-reader/punch on PL19/PL20.
// Host words are serialised LSB first onto PL19; PL20 bits are assembled into host words.
module accessory_port
    import g15_accessory_pkg::*;
#(
    parameter int WORD_W    = G15_WORD_W,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              PL19_START_INPUT,
    input  logic              PL19_STOP_INPUT,
    input  logic              PL19_SHIFT_CMD_M20,
    output logic              PL19_INPUT,
    input  logic              PL20_OUTPUT,
    input  logic              PL20_OUT_EN,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              input_active,
    output logic              underrun,
    output logic              overflow,
    input  logic              clr_status
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam int IN_CW = $clog2(IN_DEPTH + 1);
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    in_state_t          state;
    in_state_t          state_nxt;
    logic [WORD_W-1:0]  in_sr;
    logic [WORD_W-1:0]  in_head;
    logic [CNT_W-1:0]   in_cnt;
    logic               in_empty;
    logic               in_full;
    logic [IN_CW-1:0]   in_count;
    logic               in_push;
    logic               in_load;
    logic               shift_last;
    logic               run_q;

    logic [WORD_W-1:0]  out_sr;
    logic [WORD_W-1:0]  out_word;
    logic [WORD_W-1:0]  out_head;
    logic [CNT_W-1:0]   out_cnt;
    logic               out_done;
    logic               out_empty;
    logic               out_full;
    logic [OUT_CW-1:0]  out_count;
    logic               unused_sig;

    assign unused_sig = ^{in_full, out_count};

    // in_ready comes from registers only; run_q keeps it low through reset.
    assign in_ready   = run_q && (in_count != IN_CW'(IN_DEPTH));
    assign in_push    = in_valid && in_ready;
    assign shift_last = (state == SHIFTING) && PL19_SHIFT_CMD_M20 && (in_cnt == LAST);
    assign in_load    = !PL19_STOP_INPUT && !in_empty && ((state == ARMED) || shift_last);

    sync_fifo #(.W(WORD_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (CLOCK),
        .rst       (rst),
        .push      (in_push),
        .push_data (in_data),
        .pop       (in_load),
        .pop_data  (in_head),
        .full      (in_full),
        .empty     (in_empty),
        .count     (in_count)
    );

    always_ff @(posedge CLOCK) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (PL19_STOP_INPUT) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (PL19_START_INPUT) state_nxt = ARMED;
                ARMED:    if (!in_empty) state_nxt = SHIFTING;
                SHIFTING: if (shift_last && in_empty) state_nxt = ARMED;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        PL19_INPUT   = (state == SHIFTING) && in_sr[0];
        input_active = (state != IDLE);
    end

    // A reload on the final shift keeps consecutive words gap-free.
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            in_sr  <= '0;
            in_cnt <= '0;
        end else if (PL19_STOP_INPUT) begin
            in_cnt <= '0;
        end else if (in_load) begin
            in_sr  <= in_head;
            in_cnt <= '0;
        end else if ((state == SHIFTING) && PL19_SHIFT_CMD_M20) begin
            in_sr  <= in_sr >> 1;
            in_cnt <= in_cnt + CNT_W'(1);
        end
    end

    assign out_done = PL20_OUT_EN && (out_cnt == LAST);

    always_comb begin
        out_word           = out_sr;
        out_word[WORD_W-1] = PL20_OUTPUT;
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            out_sr  <= '0;
            out_cnt <= '0;
        end else if (PL20_OUT_EN) begin
            out_sr[out_cnt] <= PL20_OUTPUT;
            out_cnt         <= out_done ? '0 : out_cnt + CNT_W'(1);
        end
    end

    sync_fifo #(.W(WORD_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (CLOCK),
        .rst       (rst),
        .push      (out_done),
        .push_data (out_word),
        .pop       (out_ready),
        .pop_data  (out_head),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

    assign out_valid = !out_empty;
    assign out_data  = out_valid ? out_head : '0;

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            run_q    <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            underrun <= ((state == ARMED) && PL19_SHIFT_CMD_M20) || (underrun && !clr_status);
            overflow <= (out_done && out_full) || (overflow && !clr_status);
        end
    end

endmodule

// File: tb/tb_accessory_port.sv
// Directed self-checking bench for accessory_port: one task per scenario.
module tb_accessory_port;
    localparam int W = 29;

    logic         CLOCK = 1'b0;
    logic         rst = 1'b1;
    logic         PL19_START_INPUT = 1'b0;
    logic         PL19_STOP_INPUT = 1'b0;
    logic         PL19_SHIFT_CMD_M20 = 1'b0;
    logic         PL19_INPUT;
    logic         PL20_OUTPUT = 1'b0;
    logic         PL20_OUT_EN = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         input_active;
    logic         underrun;
    logic         overflow;
    logic         clr_status = 1'b0;

    int passed = 0;
    int total  = 0;

    accessory_port #(.WORD_W(W), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
        .CLOCK              (CLOCK),
        .rst                (rst),
        .PL19_START_INPUT   (PL19_START_INPUT),
        .PL19_STOP_INPUT    (PL19_STOP_INPUT),
        .PL19_SHIFT_CMD_M20 (PL19_SHIFT_CMD_M20),
        .PL19_INPUT         (PL19_INPUT),
        .PL20_OUTPUT        (PL20_OUTPUT),
        .PL20_OUT_EN        (PL20_OUT_EN),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .input_active       (input_active),
        .underrun           (underrun),
        .overflow           (overflow),
        .clr_status         (clr_status)
    );

    always #5 CLOCK = ~CLOCK;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_word(input logic [W-1:0] w);
        total++;
        if (in_ready !== 1'b1) $display("FAIL push_ready: in_ready=%b expected 1", in_ready);
        else passed++;
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_and_load();
        PL19_START_INPUT = 1'b1;
        tick();
        PL19_START_INPUT = 1'b0;
        tick();
    endtask

    task automatic stop_input();
        PL19_STOP_INPUT = 1'b1;
        tick();
        PL19_STOP_INPUT = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        push_word(29'h1555_5555);
        push_word(29'h0000_0003);
        push_word(29'h0000_0005);
        start_and_load();
        PL19_SHIFT_CMD_M20 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        PL19_SHIFT_CMD_M20 = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if ({PL19_INPUT, in_ready, out_valid, input_active, underrun, overflow} !== 6'b0)
            $display("FAIL reset_outputs: pl19,in_ready,out_valid,active,underrun,overflow=%b expected 000000",
                     {PL19_INPUT, in_ready, out_valid, input_active, underrun, overflow});
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: in_ready=%b expected 1", in_ready);
        else passed++;
        // A leftover word (LSB 1) would load and drive PL19 high if the FIFO survived reset.
        start_and_load();
        tick();
        total++;
        if ({input_active, PL19_INPUT} !== 2'b10)
            $display("FAIL reset_fifo_empty: active,pl19=%b expected 10", {input_active, PL19_INPUT});
        else passed++;
        stop_input();
    endtask

    task automatic test_stream();
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        logic         exp_bit;
        int           errs;
        wa = 29'h1555_5555;
        wb = 29'h0AAA_AAAA;
        errs = 0;
        do_reset();
        push_word(wa);
        push_word(wb);
        PL19_START_INPUT = 1'b1;
        tick();
        PL19_START_INPUT = 1'b0;
        total++;
        if (input_active !== 1'b1) $display("FAIL stream_armed: input_active=%b expected 1", input_active);
        else passed++;
        tick();
        PL19_SHIFT_CMD_M20 = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            exp_bit = (i < W) ? wa[i] : wb[i - W];
            if (PL19_INPUT !== exp_bit) begin
                errs++;
                $display("FAIL stream_bit %0d: PL19_INPUT=%b expected %b", i, PL19_INPUT, exp_bit);
            end
            tick();
        end
        PL19_SHIFT_CMD_M20 = 1'b0;
        total++;
        if (errs != 0) $display("FAIL stream_bits: %0d bit errors expected 0", errs);
        else passed++;
        total++;
        if ({input_active, PL19_INPUT, underrun} !== 3'b100)
            $display("FAIL stream_end: active,pl19,underrun=%b expected 100",
                     {input_active, PL19_INPUT, underrun});
        else passed++;
    endtask

    task automatic test_underrun();
        // Continues from ARMED with an empty FIFO.
        PL19_SHIFT_CMD_M20 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (PL19_INPUT !== 1'b0) $display("FAIL underrun_bit %0d: PL19_INPUT=%b expected 0", i, PL19_INPUT);
            else passed++;
            tick();
        end
        PL19_SHIFT_CMD_M20 = 1'b0;
        total++;
        if (underrun !== 1'b1) $display("FAIL underrun_set: underrun=%b expected 1", underrun);
        else passed++;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total++;
        if (underrun !== 1'b0) $display("FAIL underrun_clr: underrun=%b expected 0", underrun);
        else passed++;
        PL19_SHIFT_CMD_M20 = 1'b1;
        clr_status = 1'b1;
        tick();
        PL19_SHIFT_CMD_M20 = 1'b0;
        clr_status = 1'b0;
        total++;
        if (underrun !== 1'b1) $display("FAIL underrun_set_beats_clr: underrun=%b expected 1", underrun);
        else passed++;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        stop_input();
    endtask

    task automatic test_stop_restart();
        // Word B = 3 emits 1,1,0; the abandoned word A would continue with 0,1,0.
        logic [2:0] exp_bits;
        exp_bits = 3'b011;
        do_reset();
        push_word(29'h1555_5555);
        push_word(29'h0000_0003);
        start_and_load();
        PL19_SHIFT_CMD_M20 = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        PL19_SHIFT_CMD_M20 = 1'b0;
        stop_input();
        total++;
        if ({input_active, PL19_INPUT} !== 2'b00)
            $display("FAIL stop_idle: active,pl19=%b expected 00", {input_active, PL19_INPUT});
        else passed++;
        start_and_load();
        PL19_SHIFT_CMD_M20 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (PL19_INPUT !== exp_bits[i])
                $display("FAIL restart_bit %0d: PL19_INPUT=%b expected %b", i, PL19_INPUT, exp_bits[i]);
            else passed++;
            tick();
        end
        PL19_SHIFT_CMD_M20 = 1'b0;
        stop_input();
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < 4; i++) push_word(29'(i + 1));
        total++;
        if (in_ready !== 1'b0) $display("FAIL fifo_full_ready: in_ready=%b expected 0", in_ready);
        else passed++;
        start_and_load();
        total++;
        if (in_ready !== 1'b1) $display("FAIL fifo_pop_ready: in_ready=%b expected 1", in_ready);
        else passed++;
        stop_input();
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic check_edge);
        for (int i = 0; i < W; i++) begin
            PL20_OUT_EN = 1'b1;
            PL20_OUTPUT = w[i];
            if (check_edge && i == W - 1) begin
                total++;
                if (out_valid !== 1'b0) $display("FAIL out_valid_early: out_valid=%b expected 0", out_valid);
                else passed++;
            end
            tick();
        end
        PL20_OUT_EN = 1'b0;
        PL20_OUTPUT = 1'b0;
        if (check_edge) begin
            total++;
            if (out_valid !== 1'b1) $display("FAIL out_valid_latency: out_valid=%b expected 1", out_valid);
            else passed++;
        end
        tick();
    endtask

    task automatic test_output();
        logic [W-1:0] wo;
        wo = 29'h1234_5678;
        do_reset();
        out_ready = 1'b0;
        send_word(wo, 1'b1);
        for (int k = 1; k < 4; k++) send_word(wo, 1'b0);
        total++;
        if (overflow !== 1'b0) $display("FAIL overflow_early: overflow=%b expected 0", overflow);
        else passed++;
        send_word(wo, 1'b0);
        total++;
        if (overflow !== 1'b1) $display("FAIL overflow_set: overflow=%b expected 1", overflow);
        else passed++;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== wo)
                $display("FAIL pop_word %0d: valid=%b data=%h expected 1 %h", k, out_valid, out_data, wo);
            else passed++;
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL out_drained: out_valid=%b expected 0", out_valid);
        else passed++;
    endtask

    task automatic test_start_stop();
        do_reset();
        PL19_START_INPUT = 1'b1;
        PL19_STOP_INPUT  = 1'b1;
        tick();
        PL19_START_INPUT = 1'b0;
        PL19_STOP_INPUT  = 1'b0;
        total++;
        if (input_active !== 1'b0) $display("FAIL start_stop_same: input_active=%b expected 0", input_active);
        else passed++;
        tick();
        total++;
        if (input_active !== 1'b0) $display("FAIL start_stop_hold: input_active=%b expected 0", input_active);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underrun();
        test_stop_restart();
        test_fifo_full();
        test_output();
        test_start_stop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
